alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the CPU datapath ALU.
- Adds a valid/ready handshake on both the operand side and the result side.
- Adds iterative unsigned multiply and divide alongside the eight single-cycle ops, and registers result and flags.
- Sits between the register-file read stage and writeback; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0]; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and fun valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand 1
- B  input  WIDTH  operand 2 or shift amount
- fun  input  4  operation select
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- R  output  WIDTH  registered result
- N  output  1  negative flag, R[WIDTH-1]
- Z  output  1  zero flag, R == 0 over WIDTH bits
- C  output  1  carry/borrow
- V  output  1  overflow or error

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; R, N, Z, C and V all 0. Reset mid-operation aborts with no output.
- States and transitions:
  - IDLE (in_ready=1): on in_valid, latch A, B and fun. Single-cycle ops go to DONE; MUL/DIVU go to BUSY.
  - BUSY: one iteration per cycle for WIDTH cycles, then DONE.
  - DONE (out_valid=1): R and flags held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- No acceptance while BUSY or DONE; in_ready is low there. A new op is accepted at the earliest in the cycle after the result handshake.
- Latency from acceptance edge to out_valid: single-cycle ops 1 cycle; MUL and DIVU WIDTH+1 cycles.
- fun encoding:
  - 0 ADD: C = carry out.
  - 1 SUB: A-B; C = bit WIDTH of the (WIDTH+1)-bit difference, i.e. 1 when A<B unsigned.
  - 2 AND; 3 OR; 4 NOR.
  - 5 LSL, 6 LSR, 7 ASR: shift by B[SHW-1:0].
  - 8 MUL: unsigned shift-add; R = low WIDTH bits; C = 1 if the high half is nonzero.
  - 9 DIVU: restoring divide; R = quotient.
  - 10-15: reserved.
- V:
  - ADD: signed overflow (same operand signs, result sign differs).
  - SUB: operand signs differ and result sign differs from A.
  - DIVU by zero: R = all ones, V=1; skips BUSY and completes in 1 cycle.
  - Reserved fun: R=0, V=1, C=0, 1-cycle latency.
  - All other ops: V=0.
- C=0 for ops 2-7.
- N and Z are always computed from the final R.
- Holding rule: once out_valid is high, R, N, Z, C and V must not change until the handshake, whatever happens on A, B, fun or in_valid.

Optional Feature:
- ALU_REM_EN defined:
  - fun 10 = REMU: shares the DIVU datapath and returns the remainder, WIDTH+1 latency.
  - Remainder by zero: R=A, V=1, 1-cycle latency.
- ALU_REM_EN undefined: fun 10 is reserved, giving R=0 and V=1. No extra remainder output register exists.

Test Plan:
- ADD, WIDTH=16: A=0x7FFF, B=0x0001, fun=0 -> out_valid 1 cycle after accept; R=0x8000, N=1, Z=0, C=0, V=1.
- SUB: A=0x0003, B=0x0005 -> R=0xFFFE, C=1, N=1, V=0. Then A=B=0x1234 -> R=0, Z=1.
- ASR: A=0x8000, B=0x0013 -> shift 3 (B[3:0]) -> R=0xF000. Then LSL with A=0x0001, B=0x000F -> R=0x8000.
- MUL: A=0x0100, B=0x0100 -> out_valid exactly 17 cycles after accept; R=0x0000, C=1, Z=1. Then A=0x00FF, B=0x0003 -> R=0x02FD, C=0.
- DIVU: A=100, B=7 -> R=14 after 17 cycles. A=5, B=0 -> R=0xFFFF, V=1 after 1 cycle. With ALU_REM_EN: REMU 100,7 -> R=2.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles with new A/B toggling and in_valid=1 -> R and flags are stable and in_ready=0 throughout.
  - Assert rst during MUL BUSY -> next cycle in_ready=1, out_valid=0, all outputs 0.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: eight single-cycle ops plus iterative unsigned MUL/DIVU, valid/ready on both sides.
// Define ALU_REM_EN to enable fun 10 = REMU (remainder from the shared divide datapath).
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       fun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] r_reg;
    logic             n_reg;
    logic             z_reg;
    logic             c_reg;
    logic             v_reg;

    // Iteration state: hi/lo form the product (MUL) or remainder/quotient (DIVU).
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [SHW-1:0]   count_reg;
    logic             mul_reg;
`ifdef ALU_REM_EN
    logic             rem_reg;
`endif

    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_r;
    logic             sc_c;
    logic             sc_v;
    logic             sc_multi;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [WIDTH-1:0] res_r;
    logic             res_c;
    logic             res_v;

    assign sh       = B[SHW-1:0];
    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_full = {1'b0, A} - {1'b0, B};

    always_comb begin
        sc_r     = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_multi = 1'b0;
        case (fun)
            4'd0: begin
                sc_r = add_full[WIDTH-1:0];
                sc_c = add_full[WIDTH];
                sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            4'd1: begin
                sc_r = sub_full[WIDTH-1:0];
                sc_c = sub_full[WIDTH];
                sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
            end
            4'd2: sc_r = A & B;
            4'd3: sc_r = A | B;
            4'd4: sc_r = ~(A | B);
            4'd5: sc_r = A << sh;
            4'd6: sc_r = A >> sh;
            4'd7: sc_r = $unsigned($signed(A) >>> sh);
            4'd8: sc_multi = 1'b1;
            4'd9: begin
                // Divide by zero short-circuits the iteration entirely.
                if (B == '0) begin
                    sc_r = '1;
                    sc_v = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
`ifdef ALU_REM_EN
            4'd10: begin
                if (B == '0) begin
                    sc_r = A;
                    sc_v = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
`endif
            default: sc_v = 1'b1;
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIVU) step per cycle.
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_reg};

    always_comb begin
        step_hi = '0;
        step_lo = '0;
        if (mul_reg) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opb_reg) : div_shift[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        res_r = sc_r;
        res_c = sc_c;
        res_v = sc_v;
        if (state_reg == BUSY) begin
            res_v = 1'b0;
            res_r = step_lo;
            res_c = mul_reg ? (|step_hi) : 1'b0;
`ifdef ALU_REM_EN
            if (rem_reg) begin
                res_r = step_hi;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            r_reg         <= '0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            opb_reg       <= '0;
            count_reg     <= '0;
            mul_reg       <= 1'b0;
`ifdef ALU_REM_EN
            rem_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        mul_reg      <= (fun == 4'd8);
`ifdef ALU_REM_EN
                        rem_reg      <= (fun == 4'd10);
`endif
                        hi_reg       <= '0;
                        lo_reg       <= (fun == 4'd8) ? B : A;
                        opb_reg      <= (fun == 4'd8) ? A : B;
                        count_reg    <= '0;
                        if (sc_multi) begin
                            state_reg <= BUSY;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            r_reg         <= res_r;
                            n_reg         <= res_r[WIDTH-1];
                            z_reg         <= (res_r == '0);
                            c_reg         <= res_c;
                            v_reg         <= res_v;
                        end
                    end
                end
                BUSY: begin
                    hi_reg    <= step_hi;
                    lo_reg    <= step_lo;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        r_reg         <= res_r;
                        n_reg         <= res_r[WIDTH-1];
                        z_reg         <= (res_r == '0);
                        c_reg         <= res_c;
                        v_reg         <= res_v;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign R         = r_reg;
    assign N         = n_reg;
    assign Z         = z_reg;
    assign C         = c_reg;
    assign V         = v_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=16): directed vector table, backpressure/reset sequences, random ops vs a model.
module tb_alu_mc;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [3:0]   fun_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] r_out;
    logic         n_out;
    logic         z_out;
    logic         c_out;
    logic         v_out;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .fun(fun_in), .out_valid(out_valid), .out_ready(out_ready),
        .R(r_out), .N(n_out), .Z(z_out), .C(c_out), .V(v_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                                  output logic [15:0] r, output logic c, output logic v, output int lat);
        int sa, sb, s;
        int unsigned ua, ub, p;
        logic [3:0] sh;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = b[3:0];
        r = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (f)
            4'd0: begin p = ua + ub; r = 16'(p); c = (p > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            4'd1: begin r = a - b; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~(a | b);
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: begin s = sa >>> sh; r = 16'(s); end
            4'd8: begin p = ua * ub; r = 16'(p); c = ((p >> 16) != 0); lat = 17; end
            4'd9: begin
                if (ub == 0) begin r = 16'hFFFF; v = 1'b1; end
                else begin r = 16'(ua / ub); lat = 17; end
            end
`ifdef ALU_REM_EN
            4'd10: begin
                if (ub == 0) begin r = a; v = 1'b1; end
                else begin r = 16'(ua % ub); lat = 17; end
            end
`endif
            default: v = 1'b1;
        endcase
    endfunction

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid_after_hs"}, out_valid, 0);
        check({tag, " in_ready_after_hs"}, in_ready, 1);
    endtask

    // Present one op, wait (bounded) for out_valid; lat counts edges from acceptance.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                          output int lat, output bit ok);
        check({tag, " in_ready_before_accept"}, in_ready, 1);
        a_in = a; b_in = b; fun_in = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " out_valid_within_bound"}, ok, 1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input logic [15:0] er, input logic ec, input logic ev, input int elat, input int hold);
        int lat;
        bit ok;
        run_op(tag, a, b, f, lat, ok);
        if (ok) begin
            check({tag, " R"}, r_out, er);
            check({tag, " N"}, n_out, er[15]);
            check({tag, " Z"}, z_out, (er == 16'h0));
            check({tag, " C"}, c_out, ec);
            check({tag, " V"}, v_out, ev);
            check({tag, " latency"}, lat, elat);
            $display("%s f=%0d a=%h b=%h -> R=%h N=%0d Z=%0d C=%0d V=%0d lat=%0d",
                     tag, f, a, b, r_out, n_out, z_out, c_out, v_out, lat);
            for (int k = 0; k < hold; k++) begin
                a_in = 16'($urandom); b_in = 16'($urandom); fun_in = 4'($urandom); in_valid = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (hold > 0) begin
                check({tag, " R_held"}, r_out, er);
                check({tag, " in_ready_held"}, in_ready, 0);
            end
        end
        handshake(tag);
    endtask

    initial begin
        int lat;
        bit ok;
        bit seen;
        logic [15:0] ra, rb, er;
        logic [3:0] rf;
        logic ec, ev;
        int elat;

        vecs.push_back(vec_t'{16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b0, 1'b1, 8'd1});
        vecs.push_back(vec_t'{16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h0003, 16'h0005, 4'd1,  16'hFFFE, 1'b1, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h1234, 16'h1234, 4'd1,  16'h0000, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h8000, 16'h7FFF, 4'd1,  16'h0001, 1'b0, 1'b1, 8'd1});
        vecs.push_back(vec_t'{16'hF0F0, 16'h3C3C, 4'd2,  16'h3030, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'hF0F0, 16'h3C3C, 4'd3,  16'hFCFC, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'hF0F0, 16'h3C3C, 4'd4,  16'h0303, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h0001, 16'h000F, 4'd5,  16'h8000, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h8000, 16'h0013, 4'd6,  16'h1000, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h8000, 16'h0013, 4'd7,  16'hF000, 1'b0, 1'b0, 8'd1});
        vecs.push_back(vec_t'{16'h0100, 16'h0100, 4'd8,  16'h0000, 1'b1, 1'b0, 8'd17});
        vecs.push_back(vec_t'{16'h00FF, 16'h0003, 4'd8,  16'h02FD, 1'b0, 1'b0, 8'd17});
        vecs.push_back(vec_t'{16'd100,  16'd7,    4'd9,  16'd14,   1'b0, 1'b0, 8'd17});
        vecs.push_back(vec_t'{16'd5,    16'd0,    4'd9,  16'hFFFF, 1'b0, 1'b1, 8'd1});
`ifdef ALU_REM_EN
        vecs.push_back(vec_t'{16'd100,  16'd7,    4'd10, 16'd2,    1'b0, 1'b0, 8'd17});
        vecs.push_back(vec_t'{16'd5,    16'd0,    4'd10, 16'd5,    1'b0, 1'b1, 8'd1});
`else
        vecs.push_back(vec_t'{16'd100,  16'd7,    4'd10, 16'h0000, 1'b0, 1'b1, 8'd1});
        vecs.push_back(vec_t'{16'd5,    16'd0,    4'd10, 16'h0000, 1'b0, 1'b1, 8'd1});
`endif
        vecs.push_back(vec_t'{16'h1234, 16'h5678, 4'd12, 16'h0000, 1'b0, 1'b1, 8'd1});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset R", r_out, 0);
        check("reset NZCV", {n_out, z_out, c_out, v_out}, 0);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f,
                  vecs[i].r, vecs[i].c, vecs[i].v, int'(vecs[i].lat), 0);
        end

        // Backpressure: result must hold for 5 cycles while inputs churn.
        run_op("bp", 16'h7FFF, 16'h0001, 4'd0, lat, ok);
        for (int k = 0; k < 5; k++) begin
            a_in = 16'($urandom); b_in = 16'($urandom); fun_in = 4'($urandom_range(0, 9)); in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d R", k), r_out, 16'h8000);
            check($sformatf("bp%0d NZCV", k), {n_out, z_out, c_out, v_out}, 4'b1001);
            check($sformatf("bp%0d in_ready", k), in_ready, 0);
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
        end
        in_valid = 1'b0;
        $display("bp held R=%h NZCV=%b%b%b%b for 5 cycles", r_out, n_out, z_out, c_out, v_out);
        handshake("bp");

        // Reset during MUL iteration aborts with no result.
        check("abort in_ready_before_accept", in_ready, 1);
        a_in = 16'h0100; b_in = 16'h0100; fun_in = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort R", r_out, 0);
        check("abort NZCV", {n_out, z_out, c_out, v_out}, 0);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no_output", seen, 0);
        $display("abort reset during MUL: R=%h out_valid=%0d", r_out, out_valid);

        for (int i = 0; i < 120; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            rf = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 10)) : 4'($urandom_range(0, 15));
            model(ra, rb, rf, er, ec, ev, elat);
            do_op($sformatf("rnd%0d", i), ra, rb, rf, er, ec, ev, elat, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
